qoa_slice_decoder: RTL and testbench
====================================

QOA_SLICE_DECODER -- requirements
Module: qoa_slice_decoder

Interface
REQ-001 Parameter: WEIGHT_W, default 32, width of the internal signed LMS weight registers.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  byte from the SPI receive stage, MSB-first big-endian stream.
REQ-005 in_valid  input  1  in_data valid; a byte transfers on a clk edge where in_valid and in_ready are both 1.
REQ-006 in_ready  output  1  block accepts a byte.
REQ-007 lms_load  input  1  sampled with the first byte of a group: 1 = 16-byte LMS-state group, 0 = 8-byte slice group.
REQ-008 sample_out  output  16  signed decoded PCM sample.
REQ-009 sample_valid  output  1  sample_out valid; it transfers on a clk edge where sample_valid and sample_ready are both 1.
REQ-010 sample_ready  input  1  downstream accepts a sample.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, LOAD_LMS, LOAD_SLICE, MAC, FINAL, OUT.
REQ-013 IDLE: in_ready=1; accepted byte with lms_load=1 -> LOAD_LMS, with lms_load=0 -> LOAD_SLICE; the first byte counts as byte 0 of its group.
REQ-014 LOAD_LMS: in_ready=1 until 16 bytes are taken: history[0..3] then weights[0..3], each int16 big-endian, weights sign-extended to WEIGHT_W; then -> IDLE.
REQ-015 LOAD_SLICE: in_ready=1 until 8 bytes form a 64-bit word (first byte = bits 63:56); sf=bits 63:60, residual n (n=0..19) = bits 59-3n:57-3n; then -> MAC with sample index 0.
REQ-016 in_ready SHALL be 0 in MAC, FINAL and OUT; lms_load is ignored except on the first byte of a group.
REQ-017 MAC: 4 cycles, one signed history[i]*weight[i] product accumulated per cycle, i=0..3, into an accumulator of at least 50 bits cleared on entry.
REQ-018 FINAL (1 cycle): pred = acc >>> 13; deq = dequant(sf, q_n); s = clamp(pred+deq, -32768, 32767); delta = deq >>> 4; for each i: weight[i] += (history[i] < 0) ? -delta : delta, using pre-shift history; history shifts down by one, history[3] = s; sample_out <= s.
REQ-019 dequant(sf,q) SHALL equal round-half-away-from-zero(SF[sf] * B[q]); SF = {1,7,21,45,84,138,211,304,421,562,731,928,1157,1419,1715,2048}, B = {0.75,-0.75,2.5,-2.5,4.5,-4.5,7,-7}.
REQ-020 OUT: sample_valid=1 and sample_out held stable until the handshake; on handshake -> MAC for the next sample, or -> IDLE after sample 19.
REQ-021 Latency: sample_valid first rises 6 clk edges after the edge accepting the last slice byte; with sample_ready held at 1, throughput is 1 sample per 6 cycles.
REQ-022 LMS state SHALL persist across slices and change only by REQ-014 or REQ-018.
REQ-023 Weight arithmetic SHALL wrap at WEIGHT_W bits; no saturation is applied to the weights.

Reset
REQ-024 When rst_n=0 at a clk edge: state=IDLE, sample_valid=0, sample_out=0, byte and sample counters=0, history and weights=0, accumulator=0, regardless of the current state.
REQ-025 in_ready SHALL read 1 in the first cycle after reset is released; a partially received group or in-flight slice is discarded.

Structure
REQ-026 Package qoa_pkg SHALL hold the SF table, B table (as x4 integers), LMS_SHIFT=13, SLICE_LEN=20, LMS_BYTES=16, SLICE_BYTES=8, and the FSM state enum.
REQ-027 The dequant lookup SHALL be one combinational sub-module, qoa_dequant (sf[3:0], q[2:0] -> signed 16-bit).

Verification
REQ-028 LMS all zero, slice 0x0000_0000_0000_0000 -> 20 samples each = 1, weights stay 0.
REQ-029 LMS all zero, slice sf=15 with all residuals=6 -> sample0=14336, sample1=15904; weights after sample0 = 896 each.
REQ-030 History all 32767, weights all 8192, sf=15, q=6 -> sample0 clamps to 32767; history all -32768, q=7 -> clamps to -32768.
REQ-031 sample_ready held 0 for 10 cycles during OUT -> sample_valid stays 1, sample_out unchanged, in_ready stays 0; release -> next sample appears 6 cycles later.
REQ-032 rst_n pulsed low during MAC of sample 5 -> next cycle state IDLE, sample_valid=0, in_ready=1, a fresh zero-LMS slice replays the REQ-028 output.

Source files
------------

// File: rtl/qoa_pkg.sv
// qoa_pkg: shared constants, lookup tables and FSM state type for the QOA
// slice decoder.
//   SF_TAB     : 16-entry scale-factor table indexed by the 4-bit slice sf field
//   B4_TAB     : 8-entry dequantisation table, stored as 4x integer multipliers
//   LMS_SHIFT  : right shift applied to the LMS accumulator to form the prediction
//   SLICE_LEN  : samples carried by one 64-bit slice
//   LMS_BYTES  : bytes in an LMS-state group (4 history + 4 weights, int16 each)
//   SLICE_BYTES: bytes in a slice group
package qoa_pkg;

    localparam int LMS_SHIFT   = 13;
    localparam int SLICE_LEN   = 20;
    localparam int LMS_BYTES   = 16;
    localparam int SLICE_BYTES = 8;

    localparam int SF_TAB [16] = '{1, 7, 21, 45, 84, 138, 211, 304,
                                   421, 562, 731, 928, 1157, 1419, 1715, 2048};

    // 0.75, -0.75, 2.5, -2.5, 4.5, -4.5, 7, -7 scaled by 4 so the table is integral
    localparam int B4_TAB [8] = '{3, -3, 10, -10, 18, -18, 28, -28};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_LMS   = 3'd1,
        ST_LOAD_SLICE = 3'd2,
        ST_MAC        = 3'd3,
        ST_FINAL      = 3'd4,
        ST_OUT        = 3'd5
    } qoa_state_e;

endpackage

// File: rtl/qoa_dequant.sv
// qoa_dequant: combinational residual dequantiser.
//   sf  : 4-bit scale-factor index
//   q   : 3-bit quantised residual
//   deq : signed 16-bit result, round-half-away-from-zero(SF[sf] * B[q])
module qoa_dequant
    import qoa_pkg::*;
(
    input  logic [3:0]  sf,
    input  logic [2:0]  q,
    output logic [15:0] deq
);

    logic signed [17:0] w_prod;
    logic        [17:0] w_mag;
    logic        [15:0] w_rnd;

    // The table holds B*4, so the product is 4x the real value: adding 2 and
    // shifting right by 2 on the magnitude rounds halves away from zero.
    always_comb begin
        w_prod = 18'(SF_TAB[sf] * B4_TAB[q]);
        w_mag  = w_prod[17] ? -w_prod : w_prod;
        w_rnd  = 16'((w_mag + 18'd2) >> 2);
        deq    = w_prod[17] ? (16'd0 - w_rnd) : w_rnd;
    end

endmodule

// File: rtl/qoa_slice_decoder.sv
// qoa_slice_decoder: decodes QOA slices into 16-bit PCM samples.
//   clk          : clock, all logic on the rising edge
//   rst_n        : synchronous active-low reset
//   in_data      : byte stream, big-endian, MSB-first
//   in_valid     : in_data valid (transfers when in_valid & in_ready)
//   in_ready     : decoder can take a byte (IDLE / LOAD_LMS / LOAD_SLICE)
//   lms_load     : sampled with the first byte of a group, 1 = 16-byte LMS
//                  state group, 0 = 8-byte slice group
//   sample_out   : signed decoded sample
//   sample_valid : sample_out valid (transfers when sample_valid & sample_ready)
//   sample_ready : downstream accepts a sample
//   busy         : high in every state except IDLE
// Each sample takes 4 MAC cycles, 1 FINAL cycle and at least 1 OUT cycle.
module qoa_slice_decoder
    import qoa_pkg::*;
#(
    parameter int WEIGHT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lms_load,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy
);

    // Product of int16 history and WEIGHT_W weight, plus 2 bits of growth for
    // the four-term sum; never narrower than 50 bits.
    localparam int PROD_W = WEIGHT_W + 16;
    localparam int ACC_W  = (WEIGHT_W + 18 > 50) ? WEIGHT_W + 18 : 50;

    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-32'sd32768);

    function automatic logic signed [15:0] clamp16(input logic signed [ACC_W-1:0] v);
        if (v > C_MAX)
            return 16'sh7FFF;
        else if (v < C_MIN)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    qoa_state_e                 r_state;
    logic [3:0]                 r_byte_cnt;
    logic [4:0]                 r_sample_idx;
    logic [1:0]                 r_mac_cnt;
    logic [7:0]                 r_hi;
    logic [63:0]                r_slice;
    logic signed [15:0]         r_hist   [4];
    logic signed [WEIGHT_W-1:0] r_weight [4];
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [15:0]         r_sample;

    logic                       w_in_ready;
    logic [5:0]                 w_lsb;
    logic [3:0]                 w_sf;
    logic [2:0]                 w_q;
    logic [15:0]                w_deq;
    logic signed [15:0]         w_deq_s;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_pred;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [15:0]         w_s;
    logic signed [15:0]         w_delta;
    logic signed [WEIGHT_W-1:0] w_delta_w;

    assign w_in_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD_LMS) ||
                        (r_state == ST_LOAD_SLICE);

    // Residual n sits at bits 59-3n : 57-3n of the slice word.
    assign w_lsb = 6'd57 - (6'(r_sample_idx) * 6'd3);
    assign w_sf  = r_slice[63:60];
    assign w_q   = r_slice[w_lsb +: 3];

    qoa_dequant u_dequant (
        .sf  (w_sf),
        .q   (w_q),
        .deq (w_deq)
    );

    assign w_deq_s   = $signed(w_deq);
    assign w_prod    = PROD_W'(r_hist[r_mac_cnt]) * PROD_W'(r_weight[r_mac_cnt]);
    assign w_pred    = r_acc >>> LMS_SHIFT;
    assign w_sum     = w_pred + ACC_W'(w_deq_s);
    assign w_s       = clamp16(w_sum);
    assign w_delta   = w_deq_s >>> 4;
    assign w_delta_w = WEIGHT_W'(w_delta);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_sample_idx <= '0;
            r_mac_cnt    <= '0;
            r_hi         <= '0;
            r_slice      <= '0;
            r_acc        <= '0;
            r_sample     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_hist[i]   <= '0;
                r_weight[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_byte_cnt <= 4'd1;
                        if (lms_load) begin
                            r_hi    <= in_data;
                            r_state <= ST_LOAD_LMS;
                        end else begin
                            r_slice <= {56'd0, in_data};
                            r_state <= ST_LOAD_SLICE;
                        end
                    end
                end

                // Even bytes hold the high half; odd bytes complete an int16.
                // Bytes 0-7 are history[0..3], bytes 8-15 are weights[0..3].
                ST_LOAD_LMS: begin
                    if (in_valid) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        if (!r_byte_cnt[0])
                            r_hi <= in_data;
                        else if (!r_byte_cnt[3])
                            r_hist[r_byte_cnt[2:1]] <= {r_hi, in_data};
                        else
                            r_weight[r_byte_cnt[2:1]] <= WEIGHT_W'($signed({r_hi, in_data}));
                        if (r_byte_cnt == 4'(LMS_BYTES - 1)) begin
                            r_byte_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end

                // Shifting left leaves the first byte at bits 63:56 after 8 bytes.
                ST_LOAD_SLICE: begin
                    if (in_valid) begin
                        r_slice    <= {r_slice[55:0], in_data};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        if (r_byte_cnt == 4'(SLICE_BYTES - 1)) begin
                            r_byte_cnt   <= '0;
                            r_sample_idx <= '0;
                            r_mac_cnt    <= '0;
                            r_acc        <= '0;
                            r_state      <= ST_MAC;
                        end
                    end
                end

                ST_MAC: begin
                    r_acc     <= r_acc + ACC_W'(w_prod);
                    r_mac_cnt <= r_mac_cnt + 2'd1;
                    if (r_mac_cnt == 2'd3)
                        r_state <= ST_FINAL;
                end

                // Weight update uses the history before this cycle's shift.
                ST_FINAL: begin
                    for (int i = 0; i < 4; i++)
                        r_weight[i] <= r_weight[i] + (r_hist[i][15] ? -w_delta_w : w_delta_w);
                    r_hist[0] <= r_hist[1];
                    r_hist[1] <= r_hist[2];
                    r_hist[2] <= r_hist[3];
                    r_hist[3] <= w_s;
                    r_sample  <= w_s;
                    r_state   <= ST_OUT;
                end

                ST_OUT: begin
                    if (sample_ready) begin
                        if (r_sample_idx == 5'(SLICE_LEN - 1)) begin
                            r_sample_idx <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_sample_idx <= r_sample_idx + 5'd1;
                            r_mac_cnt    <= '0;
                            r_acc        <= '0;
                            r_state      <= ST_MAC;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign sample_valid = (r_state == ST_OUT);
    assign sample_out   = r_sample;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qoa_slice_decoder.sv
// tb_qoa_slice_decoder: directed bench for qoa_slice_decoder with
// hand-computed expected samples, latencies and handshake behaviour.
module tb_qoa_slice_decoder;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               lms_load;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic signed [15:0] samp [20];
    int                 lat  [20];

    localparam logic [63:0] SLICE_ZERO = 64'h0;
    localparam logic [63:0] SLICE_Q6   = {4'hF, {20{3'b110}}};
    localparam logic [63:0] SLICE_Q7   = {4'hF, {20{3'b111}}};

    qoa_slice_decoder #(.WEIGHT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lms_load     (lms_load),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lms);
        @(negedge clk);
        in_data  = b;
        lms_load = lms;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lms_load = 1'b0;
    endtask

    task automatic load_lms(input logic [15:0] h, input logic [15:0] w);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = (i < 8) ? h : w;
            send_byte(i[0] ? v[7:0] : v[15:8], i == 0);
            if (i == 0) begin
                check_val("lms_busy", busy, 1);
                check_val("lms_in_ready", in_ready, 1);
            end
        end
        check_val("lms_done_idle", busy, 0);
    endtask

    task automatic send_slice(input logic [63:0] w, input logic junk_lms);
        for (int i = 0; i < 8; i++)
            send_byte(w[63 - 8*i -: 8], (i == 0) ? 1'b0 : junk_lms);
    endtask

    // Counts rising edges from the accepting/handshake edge (inclusive) until
    // sample_valid is seen, returning on the falling edge where it is seen.
    task automatic wait_valid(output int edges);
        logic seen;
        seen  = 1'b0;
        edges = 1;
        while (!seen && edges < 64) begin
            @(negedge clk);
            if (sample_valid)
                seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        if (!seen)
            check_val("valid_timeout", 0, 1);
    endtask

    task automatic collect(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            wait_valid(lat[k]);
            samp[k] = sample_out;
        end
    endtask

    task automatic run_slice(input logic [63:0] w, input logic junk_lms);
        send_slice(w, junk_lms);
        collect(0, 20);
    endtask

    initial begin
        int e;
        rst_n        = 1'b0;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        lms_load     = 1'b0;
        sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_sample_out", sample_out, 0);

        // Zero LMS, zero slice: every sample is dequant(0,0) = round(0.75) = 1.
        // lms_load is driven high on bytes 1..7 to confirm it is ignored there.
        load_lms(16'h0000, 16'h0000);
        run_slice(SLICE_ZERO, 1'b1);
        for (int k = 0; k < 20; k++)
            check_val($sformatf("zero_s%0d", k), samp[k], 1);
        check_val("latency_first", lat[0], 6);
        check_val("period_s1", lat[1], 6);
        check_val("period_s19", lat[19], 6);
        @(posedge clk);
        #1;
        check_val("slice_done_idle", busy, 0);
        check_val("slice_done_ready", in_ready, 1);

        // Weights stayed zero, so a second zero slice still yields 1s.
        run_slice(SLICE_ZERO, 1'b0);
        check_val("zero2_s0", samp[0], 1);
        check_val("zero2_s19", samp[19], 1);

        // sf=15, q=6: deq = 2048*7 = 14336, delta 896 per weight.
        load_lms(16'h0000, 16'h0000);
        run_slice(SLICE_Q6, 1'b0);
        check_val("q6_s0", samp[0], 14336);
        check_val("q6_s1", samp[1], 15904);
        check_val("q6_s2", samp[2], 20951);

        // Positive saturation.
        load_lms(16'h7FFF, 16'h2000);
        run_slice(SLICE_Q6, 1'b0);
        check_val("clamp_hi_s0", samp[0], 32767);
        check_val("clamp_hi_s1", samp[1], 32767);

        // Negative saturation.
        load_lms(16'h8000, 16'h2000);
        run_slice(SLICE_Q7, 1'b0);
        check_val("clamp_lo_s0", samp[0], -32768);
        check_val("clamp_lo_s1", samp[1], -32768);

        // Backpressure: hold sample_ready low for 10 cycles during OUT.
        load_lms(16'h0000, 16'h0000);
        send_slice(SLICE_ZERO, 1'b0);
        wait_valid(e);
        check_val("bp_first_lat", e, 6);
        sample_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val($sformatf("bp_valid_c%0d", c), sample_valid, 1);
            check_val($sformatf("bp_out_c%0d", c), sample_out, 1);
            check_val($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
        end
        sample_ready = 1'b1;
        wait_valid(e);
        check_val("bp_release_lat", e, 6);
        check_val("bp_s1", sample_out, 1);
        collect(2, 18);
        check_val("bp_s19", samp[19], 1);

        // Reset during MAC of sample 5.
        load_lms(16'h0000, 16'h0000);
        send_slice(SLICE_ZERO, 1'b0);
        collect(0, 5);
        @(posedge clk);
        @(negedge clk);
        check_val("mid_busy_mac", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_valid", sample_valid, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        check_val("mid_rst_out", sample_out, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", in_ready, 1);
        run_slice(SLICE_ZERO, 1'b0);
        for (int k = 0; k < 20; k++)
            check_val($sformatf("replay_s%0d", k), samp[k], 1);
        check_val("replay_latency", lat[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
